// File: rtl/puf_challenge_seq.sv
// LFSR-driven challenge sequencer for the LSPUF core: drives c/tigSignal, waits for respReady,
// and forwards {c, respBitA, respBits} records over valid/ready. Optional macro: PUF_SEQ_TIMEOUT_EN.
module puf_challenge_seq #(
    parameter int unsigned CHAL_W      = 16,
    parameter int unsigned RA_W        = 10,
    parameter int unsigned RS_W        = 9,
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned LOW_CYC     = 2,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [CHAL_W-1:0]           seed,
    input  logic [15:0]                 num_chal,
    output logic [CHAL_W-1:0]           c,
    output logic                        tigSignal,
    input  logic                        respReady,
    input  logic [RA_W-1:0]             respBitA,
    input  logic [RS_W-1:0]             respBits,
    output logic                        rec_valid,
    input  logic                        rec_ready,
    output logic [CHAL_W+RA_W+RS_W-1:0] rec_data,
    output logic                        busy,
    output logic                        done,
    output logic                        timeout_err
);

    localparam int unsigned RecW   = CHAL_W + RA_W + RS_W;
    localparam int unsigned CntMax = (SETTLE_CYC > LOW_CYC) ? SETTLE_CYC : LOW_CYC;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    // The LFSR taps are hard-wired for a 16-bit challenge.
    if (CHAL_W != 16 || SETTLE_CYC < 1 || LOW_CYC < 1 || TIMEOUT_CYC < 1) begin : g_param_err
        $error("puf_challenge_seq: illegal parameterisation");
    end

    typedef enum logic [2:0] {
        StIdle, StSettle, StTrig, StCapture, StOut, StRelease, StFinish
    } state_e;

    state_e            state_q, state_d;
    logic [CHAL_W-1:0] c_q, c_d;
    logic              tig_q, tig_d;
    logic [15:0]       rem_q, rem_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              rec_valid_q, rec_valid_d;
    logic [RecW-1:0]   rec_data_q, rec_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              terr_q, terr_d;
    logic              rr_meta_q, rr_sync_q;
    logic [CHAL_W-1:0] lfsr_next;

`ifdef PUF_SEQ_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
    logic [TmoW-1:0] tmo_q, tmo_d;
`endif

    assign lfsr_next = {c_q[14:0], c_q[15] ^ c_q[13] ^ c_q[12] ^ c_q[10]};

    always_comb begin
        state_d     = state_q;
        c_d         = c_q;
        tig_d       = tig_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        rec_valid_d = rec_valid_q;
        rec_data_d  = rec_data_q;
        done_d      = 1'b0;
        terr_d      = terr_q;
`ifdef PUF_SEQ_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    terr_d = 1'b0;
                    c_d    = (seed == '0) ? CHAL_W'(1) : seed;
                    rem_d  = num_chal;
                    cnt_d  = '0;
                    if (num_chal == 16'd0) begin
                        state_d = StFinish;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StSettle;
                    end
                end
            end
            StSettle: begin
                if (cnt_q == CntW'(SETTLE_CYC - 1)) begin
                    state_d = StTrig;
                    tig_d   = 1'b1;
`ifdef PUF_SEQ_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StTrig: begin
                if (rr_sync_q) begin
                    state_d = StCapture;
                end
`ifdef PUF_SEQ_TIMEOUT_EN
                else if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
                    terr_d  = 1'b1;
                    tig_d   = 1'b0;
                    state_d = StFinish;
                    done_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            StCapture: begin
                // Buses are only sampled once the synchronised ready is seen, so they are settled.
                rec_data_d  = {c_q, respBitA, respBits};
                rec_valid_d = 1'b1;
                state_d     = StOut;
            end
            StOut: begin
                if (rec_ready) begin
                    rec_valid_d = 1'b0;
                    tig_d       = 1'b0;
                    rem_d       = rem_q - 16'd1;
                    cnt_d       = '0;
                    state_d     = StRelease;
                end
            end
            StRelease: begin
                if (cnt_q < CntW'(LOW_CYC - 1)) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (!rr_sync_q) begin
                    if (rem_q == 16'd0) begin
                        state_d = StFinish;
                        done_d  = 1'b1;
                    end else begin
                        c_d     = lfsr_next;
                        cnt_d   = '0;
                        state_d = StSettle;
                    end
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            c_q         <= '0;
            tig_q       <= 1'b0;
            rem_q       <= '0;
            cnt_q       <= '0;
            rec_valid_q <= 1'b0;
            rec_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            terr_q      <= 1'b0;
            rr_meta_q   <= 1'b0;
            rr_sync_q   <= 1'b0;
`ifdef PUF_SEQ_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            c_q         <= c_d;
            tig_q       <= tig_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            rec_valid_q <= rec_valid_d;
            rec_data_q  <= rec_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            terr_q      <= terr_d;
            rr_meta_q   <= respReady;
            rr_sync_q   <= rr_meta_q;
`ifdef PUF_SEQ_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign c           = c_q;
    assign tigSignal   = tig_q;
    assign rec_valid   = rec_valid_q;
    assign rec_data    = rec_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_puf_challenge_seq.sv
// Directed bench for puf_challenge_seq with a behavioural PUF responder and a record monitor.
module tb_puf_challenge_seq;

    localparam int unsigned SETTLE   = 4;
    localparam int unsigned LOWC     = 2;
    localparam int unsigned TMO      = 32;
    localparam int unsigned RESP_DLY = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] seed;
    logic [15:0] num_chal;
    logic [15:0] c;
    logic        tigSignal;
    logic        respReady;
    logic [9:0]  respBitA;
    logic [8:0]  respBits;
    logic        rec_valid;
    logic        rec_ready;
    logic [34:0] rec_data;
    logic        busy;
    logic        done;
    logic        timeout_err;

    int n_chk  = 0;
    int n_fail = 0;

    puf_challenge_seq #(
        .CHAL_W(16), .RA_W(10), .RS_W(9),
        .SETTLE_CYC(SETTLE), .LOW_CYC(LOWC), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .num_chal(num_chal),
        .c(c), .tigSignal(tigSignal), .respReady(respReady), .respBitA(respBitA),
        .respBits(respBits), .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_data(rec_data), .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] fa(input logic [15:0] ch);
        return ch[9:0] ^ 10'h2A5;
    endfunction

    function automatic logic [8:0] fb(input logic [15:0] ch);
        return ch[15:7] ^ 9'h0C3;
    endfunction

    function automatic logic [34:0] exp_rec(input logic [15:0] ch);
        return {ch, fa(ch), fb(ch)};
    endfunction

    // PUF model: ready RESP_DLY cycles after trigger, released when trigger drops.
    logic resp_en;
    int   rcnt;
    always @(posedge clk) begin
        if (!tigSignal || !resp_en) begin
            respReady <= 1'b0;
            rcnt      <= 0;
        end else if (rcnt >= RESP_DLY - 1) begin
            respReady <= 1'b1;
        end else begin
            rcnt <= rcnt + 1;
        end
    end
    assign respBitA = respReady ? fa(c) : 10'h000;
    assign respBits = respReady ? fb(c) : 9'h000;

    logic [34:0] recs[$];
    int          n_done  = 0;
    int          n_valid = 0;
    always @(posedge clk) begin
        if (rec_valid && rec_ready) recs.push_back(rec_data);
        if (done) n_done++;
        if (rec_valid) n_valid++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic do_start(input logic [15:0] s, input logic [15:0] n);
        @(negedge clk);
        seed     = s;
        num_chal = n;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget && busy; i++) @(negedge clk);
        chk(tag, busy, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_c"}, c, 0);
        chk({tag, "_tig"}, tigSignal, 0);
        chk({tag, "_rec_valid"}, rec_valid, 0);
        chk({tag, "_rec_data"}, rec_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_terr"}, timeout_err, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [15:0] exp_c [3];
        logic [34:0] snap;
        int br;
        int bd;
        int bv;
        exp_c = '{16'hACE1, 16'h59C3, 16'hB387};

        rst_n = 1'b0; start = 1'b0; seed = '0; num_chal = '0;
        rec_ready = 1'b1; resp_en = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Three-challenge run from 0xACE1, no backpressure.
        br = recs.size(); bd = n_done;
        do_start(16'hACE1, 16'd3);
        chk("run3_c_seed", c, 16'hACE1);
        chk("run3_busy", busy, 1);
        chk("run3_tig_early", tigSignal, 0);
        repeat (SETTLE - 1) @(negedge clk);
        chk("run3_tig_settle", tigSignal, 0);
        @(negedge clk);
        chk("run3_tig_rise", tigSignal, 1);
        wait_idle("run3_idle", 300);
        chk("run3_nrec", recs.size() - br, 3);
        for (int i = 0; i < 3; i++) begin
            if (recs.size() > br + i) chk("run3_rec", recs[br + i], exp_rec(exp_c[i]));
        end
        chk("run3_ndone", n_done - bd, 1);
        chk("run3_terr", timeout_err, 0);

        // Zero seed falls back to 0x0001.
        br = recs.size(); bd = n_done;
        do_start(16'h0000, 16'd1);
        chk("seed0_c", c, 16'h0001);
        wait_idle("seed0_idle", 200);
        chk("seed0_nrec", recs.size() - br, 1);
        if (recs.size() > br) chk("seed0_rec", recs[br], exp_rec(16'h0001));
        chk("seed0_ndone", n_done - bd, 1);

        // Backpressure: 20 cycles in OUT with everything held.
        rec_ready = 1'b0;
        br = recs.size(); bd = n_done;
        do_start(16'h1234, 16'd1);
        for (int i = 0; i < 60 && !rec_valid; i++) @(negedge clk);
        chk("bp_valid", rec_valid, 1);
        snap = rec_data;
        chk("bp_data", snap, exp_rec(16'h1234));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", rec_valid, 1);
            chk("bp_hold_data", rec_data, snap);
            chk("bp_hold_tig", tigSignal, 1);
        end
        chk("bp_no_rec_yet", recs.size() - br, 0);
        rec_ready = 1'b1;
        wait_idle("bp_idle", 200);
        chk("bp_nrec", recs.size() - br, 1);
        if (recs.size() > br) chk("bp_rec", recs[br], exp_rec(16'h1234));
        chk("bp_ndone", n_done - bd, 1);

`ifdef PUF_SEQ_TIMEOUT_EN
        resp_en = 1'b0;
        br = recs.size(); bd = n_done;
        do_start(16'h5555, 16'd2);
        wait_idle("tmo_idle", SETTLE + TMO + 40);
        chk("tmo_terr", timeout_err, 1);
        chk("tmo_tig", tigSignal, 0);
        chk("tmo_nrec", recs.size() - br, 0);
        chk("tmo_ndone", n_done - bd, 1);
        resp_en = 1'b1;
        do_start(16'h0000, 16'd0);
        chk("tmo_clear", timeout_err, 0);
        wait_idle("tmo_clear_idle", 20);
`else
        resp_en = 1'b0;
        br = recs.size();
        do_start(16'h5555, 16'd1);
        repeat (60) @(negedge clk);
        chk("hang_tig", tigSignal, 1);
        chk("hang_busy", busy, 1);
        chk("hang_terr", timeout_err, 0);
        resp_en = 1'b1;
        wait_idle("hang_idle", 200);
        chk("hang_nrec", recs.size() - br, 1);
        if (recs.size() > br) chk("hang_rec", recs[br], exp_rec(16'h5555));
`endif

        // Asynchronous reset while the second challenge is in TRIG.
        br = recs.size();
        do_start(16'hACE1, 16'd3);
        for (int i = 0; i < 200 && !(recs.size() > br && tigSignal); i++) @(negedge clk);
        chk("rst_first_rec", recs.size() - br, 1);
        chk("rst_c2", c, 16'h59C3);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        br = recs.size(); bd = n_done;
        do_start(16'hBEEF, 16'd1);
        chk("rst_new_c", c, 16'hBEEF);
        wait_idle("rst_new_idle", 200);
        chk("rst_new_nrec", recs.size() - br, 1);
        if (recs.size() > br) chk("rst_new_rec", recs[br], exp_rec(16'hBEEF));
        chk("rst_new_ndone", n_done - bd, 1);

        // start while busy is ignored.
        br = recs.size(); bd = n_done;
        do_start(16'h1111, 16'd1);
        @(negedge clk);
        seed = 16'h2222; num_chal = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_c", c, 16'h1111);
        wait_idle("busy_start_idle", 200);
        repeat (10) @(negedge clk);
        chk("busy_start_busy", busy, 0);
        chk("busy_start_nrec", recs.size() - br, 1);
        if (recs.size() > br) chk("busy_start_rec", recs[br], exp_rec(16'h1111));
        chk("busy_start_ndone", n_done - bd, 1);

        // Zero-count run: single done, no record.
        br = recs.size(); bd = n_done; bv = n_valid;
        do_start(16'h7777, 16'd0);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 1);
        @(negedge clk);
        chk("zero_done_end", done, 0);
        chk("zero_busy_end", busy, 0);
        repeat (5) @(negedge clk);
        chk("zero_ndone", n_done - bd, 1);
        chk("zero_nvalid", n_valid - bv, 0);
        chk("zero_nrec", recs.size() - br, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
